// File: rtl/rainbow_gen.sv
// rainbow_gen: free-running hue-wheel colour source for the WS2812 pixel
// serializer. A prescaler paces hue steps; each step advances an 8-bit ramp
// whose carry moves through six colour segments. The raw colour is scaled by
// a global brightness and presented on registered r/g/b bytes.
module rainbow_gen #(
    parameter int unsigned STEP_TICKS = 4,   // clock cycles per hue step, >= 1
    parameter int unsigned STEP_SIZE  = 64   // ramp increment per step, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] brightness,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       wrap
);

    // Prescaler width; a single tick per step still needs one bit of counter.
    localparam int unsigned     CNT_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEP_TICKS - 1);
    localparam logic [8:0]       STEP_INC = 9'(STEP_SIZE);

    // Hue wheel segments: red->yellow->green->cyan->blue->magenta->red.
    localparam logic [2:0] SEG_0 = 3'd0;
    localparam logic [2:0] SEG_1 = 3'd1;
    localparam logic [2:0] SEG_2 = 3'd2;
    localparam logic [2:0] SEG_3 = 3'd3;
    localparam logic [2:0] SEG_4 = 3'd4;
    localparam logic [2:0] SEG_5 = 3'd5;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       seg_q, seg_d;
    logic [7:0]       v_q, v_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;
    logic             wrap_q, wrap_d;

    logic             step;
    logic [8:0]       sum;
    logic [7:0]       raw_r, raw_g, raw_b;
    logic [8:0]       bright_p1;

    // Prescaler and hue stepping: ramp carry advances the segment.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        cnt_d  = cnt_q;
        seg_d  = seg_q;
        v_d    = v_q;
        wrap_d = 1'b0;
        step   = 1'b0;
        sum    = {1'b0, v_q} + STEP_INC;

        if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (step) begin
            // The remainder carries into the next segment rather than restarting at 0.
            v_d = sum[7:0];
            if (sum[8]) begin
                if (seg_q == SEG_5) begin
                    seg_d  = SEG_0;
                    wrap_d = 1'b1;
                end else if (seg_q > SEG_5) begin
                    seg_d  = SEG_0;
                end else begin
                    seg_d  = seg_q + 3'd1;
                end
            end
        end
    end

    // Raw colour decode from segment and ramp; unused codes decode as segment 0.
    always_comb begin
        raw_r = 8'd255;
        raw_g = v_q;
        raw_b = 8'd0;
        case (seg_q)
            SEG_0: begin
                raw_r = 8'd255;
                raw_g = v_q;
                raw_b = 8'd0;
            end
            SEG_1: begin
                raw_r = 8'd255 - v_q;
                raw_g = 8'd255;
                raw_b = 8'd0;
            end
            SEG_2: begin
                raw_r = 8'd0;
                raw_g = 8'd255;
                raw_b = v_q;
            end
            SEG_3: begin
                raw_r = 8'd0;
                raw_g = 8'd255 - v_q;
                raw_b = 8'd255;
            end
            SEG_4: begin
                raw_r = v_q;
                raw_g = 8'd0;
                raw_b = 8'd255;
            end
            SEG_5: begin
                raw_r = 8'd255;
                raw_g = 8'd0;
                raw_b = 8'd255 - v_q;
            end
            default: ;
        endcase
    end

    // Brightness scaling: raw * (brightness + 1) in 17 bits, keep bits 15:8,
    // so full brightness reproduces raw exactly and zero gives black.
    always_comb begin
        bright_p1 = {1'b0, brightness} + 9'd1;
        r_d = 8'(({9'd0, raw_r} * {8'd0, bright_p1}) >> 8);
        g_d = 8'(({9'd0, raw_g} * {8'd0, bright_p1}) >> 8);
        b_d = 8'(({9'd0, raw_b} * {8'd0, bright_p1}) >> 8);
    end

    // State and output registers with synchronous reset overriding enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            cnt_q  <= '0;
            seg_q  <= SEG_0;
            v_q    <= 8'd0;
            r_q    <= 8'd0;
            g_q    <= 8'd0;
            b_q    <= 8'd0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            v_q    <= v_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            wrap_q <= wrap_d;
        end
    end

    assign r    = r_q;
    assign g    = g_q;
    assign b    = b_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_rainbow_gen.sv
// Directed testbench for rainbow_gen: reset, sweep, wrap period, brightness,
// enable hold, reset mid-sweep and ramp carry across segments.
module tb_rainbow_gen;

    logic       clk;
    logic       rst, en;
    logic [7:0] brightness;
    logic [7:0] r, g, b;
    logic       wrap;

    logic       rst_c, en_c;
    logic [7:0] brightness_c;
    logic [7:0] r_c, g_c, b_c;
    logic       wrap_c;

    int n_assert = 0;
    int n_fail   = 0;

    rainbow_gen #(.STEP_TICKS(4), .STEP_SIZE(64)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .brightness (brightness),
        .r          (r),
        .g          (g),
        .b          (b),
        .wrap       (wrap)
    );

    rainbow_gen #(.STEP_TICKS(1), .STEP_SIZE(100)) u_carry (
        .clk        (clk),
        .rst        (rst_c),
        .en         (en_c),
        .brightness (brightness_c),
        .r          (r_c),
        .g          (g_c),
        .b          (b_c),
        .wrap       (wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
        check({tag, ".r"}, {24'd0, r}, {24'd0, er});
        check({tag, ".g"}, {24'd0, g}, {24'd0, eg});
        check({tag, ".b"}, {24'd0, b}, {24'd0, eb});
    endtask

    int n_wrap;
    int first_wrap;
    int second_wrap;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        brightness = 8'd255;
        rst_c = 1'b1;
        en_c = 1'b1;
        brightness_c = 8'd255;

        // Reset held for 6 cycles
        cyc(6);
        check_rgb("reset", 8'd0, 8'd0, 8'd0);
        check("reset.wrap", {31'd0, wrap}, 32'd0);

        // First edge after release loads seg0/v0
        rst = 1'b0;
        cyc(1);                                   // edge 1
        check_rgb("first", 8'd255, 8'd0, 8'd0);

        // Sweep: a step every 4 cycles, visible one cycle later
        cyc(4);                                   // edge 5
        check_rgb("sweep_v64", 8'd255, 8'd64, 8'd0);
        cyc(4);                                   // edge 9
        check_rgb("sweep_v128", 8'd255, 8'd128, 8'd0);
        cyc(4);                                   // edge 13
        check_rgb("sweep_v192", 8'd255, 8'd192, 8'd0);
        cyc(4);                                   // edge 17
        check_rgb("sweep_seg1_v0", 8'd255, 8'd255, 8'd0);
        cyc(4);                                   // edge 21
        check_rgb("sweep_seg1_v64", 8'd191, 8'd255, 8'd0);
        check("sweep.wrap", {31'd0, wrap}, 32'd0);

        // Wrap period: pulses after edges 96 and 192 only
        n_wrap = 0;
        first_wrap = -1;
        second_wrap = -1;
        for (int e = 22; e <= 200; e++) begin
            cyc(1);
            if (wrap !== 1'b0) begin
                n_wrap++;
                if (first_wrap < 0) first_wrap = e;
                else if (second_wrap < 0) second_wrap = e;
            end
        end
        check("wrap_first_edge", first_wrap, 32'd96);
        check("wrap_second_edge", second_wrap, 32'd192);
        check("wrap_count", n_wrap, 32'd2);

        // Into seg3: step at edge 244 gives v=64, shown after edge 245
        cyc(45);                                  // edge 245
        check_rgb("seg3_v64", 8'd0, 8'd191, 8'd255);

        // Reset mid-sweep
        rst = 1'b1;
        cyc(1);
        check_rgb("midreset", 8'd0, 8'd0, 8'd0);
        check("midreset.wrap", {31'd0, wrap}, 32'd0);
        rst = 1'b0;
        cyc(1);                                   // edge 1
        check_rgb("restart", 8'd255, 8'd0, 8'd0);
        cyc(3);                                   // edge 4: step happens now, not yet visible
        check("restart_phase_e4.g", {24'd0, g}, 32'd0);
        cyc(1);                                   // edge 5
        check("restart_phase_e5.g", {24'd0, g}, 32'd64);

        // Brightness scaling while held at seg0/v64 (cnt=1)
        en = 1'b0;
        brightness = 8'd127;
        cyc(1);
        check_rgb("bright127", 8'd127, 8'd32, 8'd0);
        brightness = 8'd0;
        cyc(1);
        check_rgb("bright0", 8'd0, 8'd0, 8'd0);
        brightness = 8'd255;

        // Enable hold: outputs frozen, no wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check($sformatf("hold%0d", i), {7'd0, wrap, r, g, b}, {8'd0, 8'd255, 8'd64, 8'd0});
        end

        // Resume with preserved cnt=1: step on the 3rd edge, visible on the 4th
        en = 1'b1;
        cyc(3);
        check("resume_e3.g", {24'd0, g}, 32'd64);
        cyc(1);
        check("resume_e4.g", {24'd0, g}, 32'd128);

        // en falling when cnt==STEP_TICKS-1: step deferred until en returns
        cyc(2);                                   // cnt now 3
        en = 1'b0;
        cyc(5);
        check("defer_hold.g", {24'd0, g}, 32'd128);
        en = 1'b1;
        cyc(1);                                   // step fires on this edge
        check("defer_fire.g", {24'd0, g}, 32'd128);
        cyc(1);
        check("defer_after.g", {24'd0, g}, 32'd192);

        // Carry: STEP_TICKS=1, STEP_SIZE=100 -> v 0,100,200, then seg1/v44
        rst_c = 1'b0;
        cyc(1);
        check("carry_v0.r", {24'd0, r_c}, 32'd255);
        check("carry_v0.g", {24'd0, g_c}, 32'd0);
        cyc(1);
        check("carry_v100.g", {24'd0, g_c}, 32'd100);
        cyc(1);
        check("carry_v200.g", {24'd0, g_c}, 32'd200);
        cyc(1);
        check("carry_seg1.r", {24'd0, r_c}, 32'd211);
        check("carry_seg1.g", {24'd0, g_c}, 32'd255);
        check("carry_seg1.b", {24'd0, b_c}, 32'd0);
        check("carry_seg1.wrap", {31'd0, wrap_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
